cdb_arbiter: RTL and testbench

//  Collects results from NUM_SRC functional units (ALU, MUL, LD/ST, BR) and drives exactly one
//  tag/value pair per cycle onto the common data bus (CDB). Directly upstream of the map table and

---
 rtl/cpu_types.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared RS tag and CDB types for the result bus and its arbiter
package cpu_types;

  localparam int TAG_W       = 4;
  localparam int CDB_MAX_SRC = 8;

  typedef logic [TAG_W-1:0] RS_tag_type;

  localparam RS_tag_type INVALID = '0;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;

  typedef struct packed {
    logic held;
    cdb_t res;
  } cdb_hold_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or after ptr, with wrap
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-source holding registers, round-robin broadcast onto the CDB
// Optional CDB_STALL_CNT_EN adds per-source saturating stall counters on port stall_cnt.
module cdb_arbiter
  import cpu_types::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         fu_valid,
  input  logic [NUM_SRC*TAG_W-1:0]   fu_tag,
  input  logic [NUM_SRC*32-1:0]      fu_data,
  output logic [NUM_SRC-1:0]         fu_ready,
`ifdef CDB_STALL_CNT_EN
  output logic [NUM_SRC*16-1:0]      stall_cnt,
`endif
  output cdb_t                       cdb_out,
  output logic [SRC_IDX_W-1:0]       cdb_src
);

  cdb_hold_t            hold_q [NUM_SRC];
  cdb_hold_t            hold_d [NUM_SRC];
  logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t                 cdb_q, cdb_d;
  logic [SRC_IDX_W-1:0] src_q, src_d;

  logic [NUM_SRC-1:0]   held;
  logic [NUM_SRC-1:0]   grant;
  logic [SRC_IDX_W-1:0] grant_idx;
  logic                 grant_valid;

  rr_arbiter #(.N(NUM_SRC), .IDX_W(SRC_IDX_W)) u_rr (
    .req         (held),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    hold_d = hold_q;
    held   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      held[i] = hold_q[i].held;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      // Ready depends only on state and grant, so upstream valid never loops back.
      fu_ready[i] = !hold_q[i].held || grant[i];
      if (grant[i]) begin
        hold_d[i].held = 1'b0;
      end
      if (fu_valid[i] && fu_ready[i] && (fu_tag[i*TAG_W +: TAG_W] != INVALID)) begin
        hold_d[i].held     = 1'b1;
        hold_d[i].res.tag  = fu_tag[i*TAG_W +: TAG_W];
        hold_d[i].res.data = fu_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    cdb_d    = '{tag: INVALID, data: '0};
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      cdb_d    = hold_q[grant_idx].res;
      src_d    = grant_idx;
      rr_ptr_d = (grant_idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      cdb_q    <= '{tag: INVALID, data: '0};
      src_q    <= '0;
    end else begin
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      src_q    <= src_d;
    end
  end

  assign cdb_out = cdb_q;
  assign cdb_src = src_q;

`ifdef CDB_STALL_CNT_EN
  logic [15:0] stall_q [NUM_SRC];
  logic [15:0] stall_d [NUM_SRC];

  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      stall_d[i] = stall_q[i];
      if (held[i] && !grant[i] && (stall_q[i] != 16'hFFFF)) begin
        stall_d[i] = stall_q[i] + 16'd1;
      end
      stall_cnt[i*16 +: 16] = stall_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        stall_q[i] <= '0;
      end
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import cpu_types::*;

  logic         clk;
  logic         rst_n;
  logic [3:0]   fu_valid;
  logic [15:0]  fu_tag;
  logic [127:0] fu_data;
  logic [3:0]   fu_ready;
  cdb_t         cdb_out;
  logic [1:0]   cdb_src;
`ifdef CDB_STALL_CNT_EN
  logic [63:0]  stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_SRC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .fu_data  (fu_data),
    .fu_ready (fu_ready),
`ifdef CDB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .cdb_out  (cdb_out),
    .cdb_src  (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic [3:0] tag, input logic [31:0] data);
    fu_valid[i]           = 1'b1;
    fu_tag[i*4 +: 4]      = tag;
    fu_data[i*32 +: 32]   = data;
  endtask

  task automatic idle();
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
  endtask

  task automatic chk_cdb(input string name, input logic [3:0] tag, input logic [31:0] data,
                         input logic [1:0] src);
    chk({name, "_tag"},  64'(cdb_out.tag),  64'(tag));
    chk({name, "_data"}, 64'(cdb_out.data), 64'(data));
    chk({name, "_src"},  64'(cdb_src),      64'(src));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_tag",   64'(cdb_out.tag), 64'(INVALID));
    chk("rst_data",  64'(cdb_out.data), 64'd0);
    chk("rst_src",   64'(cdb_src), 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'hF);
`ifdef CDB_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 64'd0);
`endif
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_tag",   64'(cdb_out.tag), 64'(INVALID));
      chk("idle_ready", 64'(fu_ready), 64'hF);
    end

    // single source
    drv(1, 4'd3, 32'hDEAD_BEEF);
    step();
    idle();
    chk("single_pre_tag", 64'(cdb_out.tag), 64'(INVALID));
    chk("single_ready",   64'(fu_ready), 64'hF);
    step();
    chk_cdb("single", 4'd3, 32'hDEAD_BEEF, 2'd1);
    step();
    chk_cdb("single_after", INVALID, 32'd0, 2'd1);

    // src3 broadcast moves rr pointer back to 0
    drv(3, 4'd7, 32'h7);
    step();
    idle();
    step();
    chk_cdb("ptr_wrap", 4'd7, 32'h7, 2'd3);

    // contention, rr pointer at 0
    for (int i = 0; i < 4; i++) drv(i, 4'(i + 1), 32'(100 + i));
    step();
    idle();
    chk("cont_ready0", 64'(fu_ready), 64'b0001);
    step();
    chk_cdb("cont0", 4'd1, 32'd100, 2'd0);
    chk("cont_ready1", 64'(fu_ready), 64'b0011);
    step();
    chk_cdb("cont1", 4'd2, 32'd101, 2'd1);
    chk("cont_ready2", 64'(fu_ready), 64'b0111);
    step();
    chk_cdb("cont2", 4'd3, 32'd102, 2'd2);
    chk("cont_ready3", 64'(fu_ready), 64'b1111);
`ifdef CDB_STALL_CNT_EN
    chk("cont_stall", stall_cnt, {16'd3, 16'd2, 16'd1, 16'd0});
`endif
    step();
    chk_cdb("cont3", 4'd4, 32'd103, 2'd3);
    step();
    chk("cont_end_tag", 64'(cdb_out.tag), 64'(INVALID));

    // fairness: src0 streaming, src2 once
    drv(0, 4'd5, 32'h50);
    drv(2, 4'd6, 32'h60);
    step();
    idle();
    drv(0, 4'd5, 32'h51);
    step();
    chk_cdb("fair0", 4'd5, 32'h50, 2'd0);
    chk("fair_ready0_low", 64'(fu_ready[0]), 64'd0);
    drv(0, 4'd5, 32'h52);
    step();
    chk_cdb("fair2", 4'd6, 32'h60, 2'd2);
    chk("fair_ready0_back", 64'(fu_ready[0]), 64'd1);
    step();
    idle();
    chk_cdb("fair0b", 4'd5, 32'h51, 2'd0);
    step();
    chk_cdb("fair0c", 4'd5, 32'h52, 2'd0);
    step();
    chk("fair_end_tag", 64'(cdb_out.tag), 64'(INVALID));

    // drain and refill on src3
    drv(3, 4'd8, 32'h80);
    step();
    drv(3, 4'd8, 32'h81);
    chk("refill_ready3", 64'(fu_ready[3]), 64'd1);
    step();
    idle();
    chk_cdb("refill0", 4'd8, 32'h80, 2'd3);
    step();
    chk_cdb("refill1", 4'd8, 32'h81, 2'd3);
    step();
    chk("refill_end_tag", 64'(cdb_out.tag), 64'(INVALID));

    // INVALID-tag result is accepted and dropped
    drv(0, INVALID, 32'h99);
    chk("inv_ready", 64'(fu_ready[0]), 64'd1);
    step();
    idle();
    chk("inv_not_held", 64'(fu_ready), 64'hF);
    step();
    chk_cdb("inv_drop", INVALID, 32'd0, 2'd3);

    // async reset mid-stream
    drv(1, 4'd9, 32'h90);
    drv(2, 4'd10, 32'hA0);
    step();
    idle();
    step();
    chk_cdb("pre_rst", 4'd9, 32'h90, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cdb("async_rst", INVALID, 32'd0, 2'd0);
    chk("async_rst_ready", 64'(fu_ready), 64'hF);
    step();
    rst_n = 1'b1;
    step();
    chk_cdb("post_rst0", INVALID, 32'd0, 2'd0);
    step();
    chk_cdb("post_rst1", INVALID, 32'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
